phase_seq: RTL and testbench
============================

PHASE_SEQ -- requirements
Module: phase_seq

Interface
REQ-001 SHALL have parameter NPH, default 2: number of phase-enable outputs (1..8).
REQ-002 SHALL have parameter SLOTS, default 4: pattern table depth and maximum cycle length (2..16); SW = clog2(SLOTS).
REQ-003 SHALL have port in, input, 1: sole clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-005 SHALL have port run, input, 1: level; 1 = cycle continuously.
REQ-006 SHALL have port step, input, 1: pulse; when idle, execute exactly one full cycle.
REQ-007 SHALL have port len_we, input, 1: load len_d as pending cycle length.
REQ-008 SHALL have port len_d, input, SW+1: requested cycle length.
REQ-009 SHALL have port cfg_we, input, 1: pattern table write strobe.
REQ-010 SHALL have port cfg_addr, input, SW: table slot to write.
REQ-011 SHALL have port cfg_data, input, NPH+1: slot pattern; bit NPH = strobe, bits NPH-1:0 = phases.
REQ-012 SHALL have port ph, output, NPH: registered phase enables.
REQ-013 SHALL have port strobe, output, 1: registered accumulator-write strobe.
REQ-014 SHALL have port slot, output, SW: index of the slot whose pattern is on ph/strobe.
REQ-015 SHALL have port cycle_done, output, 1: one-cycle pulse coincident with the last slot's pattern.
REQ-016 SHALL have port busy, output, 1: 1 while a cycle is in progress.

Function
REQ-017 SHALL keep slot pointer s and active length L; when active, each edge: {strobe,ph} <= tbl[s], slot <= s, s <= (s==L-1) ? 0 : s+1.
REQ-018 SHALL have states IDLE and RUN; IDLE->RUN on edge with s==0 and (run or step); RUN->IDLE on the wrap edge (s==L-1) when run==0.
REQ-019 SHALL, in IDLE, drive ph=0, strobe=0, cycle_done=0, busy=0 and hold s=0.
REQ-020 SHALL let run deassertion mid-cycle complete the current cycle (graceful halt); no truncated cycle.
REQ-021 SHALL make step a one-cycle-only start: if run==0 the block returns to IDLE after L slots; step ignored in RUN.
REQ-022 SHALL pulse cycle_done on the output cycle carrying tbl[L-1], including the final cycle before IDLE.
REQ-023 SHALL clamp len_d: 0 or 1 -> 2, >SLOTS -> SLOTS; clamped value held pending.
REQ-024 SHALL apply pending length only at wrap (s becoming 0) or in IDLE; never mid-cycle.
REQ-025 SHALL accept cfg_we in any state; write visible from next edge; same-edge read of written slot returns old value.
REQ-026 SHALL latch only the last of multiple len_we pulses within one cycle.
REQ-027 SHALL assert busy from the first RUN output cycle through the cycle_done cycle inclusive.

Reset
REQ-028 SHALL, on rst=1 at an edge, force IDLE, s=0, slot=0, ph=0, strobe=0, cycle_done=0, busy=0, L=pending=SLOTS.
REQ-029 SHALL reload the table with the default pattern: slot k (k<SLOTS-1) phase (k mod NPH), strobe only in slot SLOTS-2, slot SLOTS-1 all-zero.
REQ-030 SHALL let rst override run, step, cfg_we, len_we in the same cycle, including mid-cycle.

Structure
REQ-031 SHALL place cfg word width and the default-pattern function in package phase_seq_pkg.
REQ-032 SHALL implement the pattern table as sub-module phase_seq_tbl (SLOTS x NPH+1 registers, 1 write port, 1 async read port, reset to default).

Verification (NPH=2, SLOTS=4)
REQ-033 SHALL check: reset, run=1 -> {strobe,ph} per cycle 0_01, 0_10, 1_01, 0_00, repeating; cycle_done on 0_00.
REQ-034 SHALL check: run dropped during slot 1 -> slots 2,3 still emitted, then ph=0, busy=0, slot=0.
REQ-035 SHALL check: idle, step pulse -> exactly 4 pattern cycles, one cycle_done, then IDLE; second step during RUN ignored.
REQ-036 SHALL check: len_we len_d=2 during slot 1 -> current cycle finishes 4 slots, then 0_01, 0_10 repeating; len_d=0 -> treated as 2.
REQ-037 SHALL check: cfg_we addr=1 data=1_11 while slot 1 read -> old 0_10 this cycle, 1_11 next pass.
REQ-038 SHALL check: rst asserted at slot 2 with run=1 -> next cycle all outputs 0, table back to default.

Source files
------------

// File: rtl/phase_seq_pkg.sv
// Shared types and helpers for the phase sequencer: FSM state encoding,
// pattern word width and the power-on default pattern table contents.
package phase_seq_pkg;

  // Largest supported phase count; bounds the width of default-pattern words.
  localparam int MAX_NPH   = 8;
  localparam int MAX_CFG_W = MAX_NPH + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Pattern word: phase enables in the low bits, accumulator strobe on top.
  function automatic int cfg_w(input int nph);
    return nph + 1;
  endfunction

  // Default table: slot k drives phase (k mod nph), the strobe fires in the
  // second-to-last slot, and the last slot is a quiet all-zero slot.
  function automatic logic [MAX_CFG_W-1:0] default_pat(input int nph, input int slots, input int k);
    logic [MAX_CFG_W-1:0] w;
    w = '0;
    if (k < slots - 1) begin
      w = MAX_CFG_W'(1) << (k % nph);
      if (k == slots - 2) begin
        w = w | (MAX_CFG_W'(1) << nph);
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/phase_seq_tbl.sv
// Pattern table: SLOTS register words, one write port, one combinational
// read port. A read of the slot being written returns the old contents.
module phase_seq_tbl
  import phase_seq_pkg::*;
#(
  parameter  int NPH   = 2,
  parameter  int SLOTS = 4,
  localparam int SW    = $clog2(SLOTS),
  localparam int CW    = cfg_w(NPH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [SW-1:0] waddr,
  input  logic [CW-1:0] wdata,
  input  logic [SW-1:0] raddr,
  output logic [CW-1:0] rdata
);

  // Padded to a power of two so every raddr value selects a defined word.
  logic [CW-1:0] words [2**SW];

  genvar gi;
  generate
    for (gi = 0; gi < 2**SW; gi++) begin : g_slot
      if (gi < SLOTS) begin : g_reg
        localparam logic [MAX_CFG_W-1:0] DEF = default_pat(NPH, SLOTS, gi);
        logic [CW-1:0] word_reg;

        // Slot storage: reload default on reset, otherwise take matching writes.
        always_ff @(posedge clk) begin
          if (rst) begin
            word_reg <= DEF[CW-1:0];
          end else if (we && (waddr == SW'(gi))) begin
            word_reg <= wdata;
          end
        end

        assign words[gi] = word_reg;
      end else begin : g_pad
        assign words[gi] = '0;
      end
    end
  endgenerate

  assign rdata = words[raddr];

endmodule

// File: rtl/phase_seq.sv
// Phase sequencer: steps through a programmable pattern table emitting
// registered phase enables and an accumulator strobe, either continuously
// (run) or for a single cycle (step). Length changes take effect only at a
// cycle boundary so a cycle is never truncated.
module phase_seq
  import phase_seq_pkg::*;
#(
  parameter  int NPH   = 2,
  parameter  int SLOTS = 4,
  localparam int SW    = $clog2(SLOTS),
  localparam int CW    = cfg_w(NPH)
) (
  input  logic           in,
  input  logic           rst,
  input  logic           run,
  input  logic           step,
  input  logic           len_we,
  input  logic [SW:0]    len_d,
  input  logic           cfg_we,
  input  logic [SW-1:0]  cfg_addr,
  input  logic [CW-1:0]  cfg_data,
  output logic [NPH-1:0] ph,
  output logic           strobe,
  output logic [SW-1:0]  slot,
  output logic           cycle_done,
  output logic           busy
);

  localparam logic [SW:0] LEN_MIN = (SW+1)'(2);
  localparam logic [SW:0] LEN_MAX = (SW+1)'(SLOTS);

  state_t         state_reg, state_next;
  logic [SW-1:0]  s_reg, s_next;
  logic [SW:0]    len_reg, len_next;
  logic [SW:0]    pend_reg, pend_next;
  logic [NPH-1:0] ph_reg, ph_next;
  logic           strobe_reg, strobe_next;
  logic [SW-1:0]  slot_reg, slot_next;
  logic           done_reg, done_next;
  logic           busy_reg, busy_next;
  logic [CW-1:0]  tbl_rdata;
  logic [SW-1:0]  s_last;

  // Lengths below 2 would make every slot a wrap slot; above SLOTS would
  // index past the table.
  function automatic logic [SW:0] clamp_len(input logic [SW:0] d);
    if (d < LEN_MIN) return LEN_MIN;
    if (d > LEN_MAX) return LEN_MAX;
    return d;
  endfunction

  phase_seq_tbl #(
    .NPH   (NPH),
    .SLOTS (SLOTS)
  ) u_tbl (
    .clk   (in),
    .rst   (rst),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (s_reg),
    .rdata (tbl_rdata)
  );

  assign s_last = SW'(len_reg - (SW+1)'(1));

  // Next-state and next-output logic; outputs default to the idle values.
  always_comb begin
    state_next  = state_reg;
    s_next      = s_reg;
    len_next    = len_reg;
    pend_next   = pend_reg;
    ph_next     = '0;
    strobe_next = 1'b0;
    slot_next   = '0;
    done_next   = 1'b0;
    busy_next   = 1'b0;

    if (len_we) begin
      pend_next = clamp_len(len_d);
    end

    case (state_reg)
      S_IDLE: begin
        // Idle tracks the pending length so a start uses the latest request.
        len_next = pend_reg;
        s_next   = '0;
        if (run || step) begin
          // Slot 0 is emitted on the start edge; length >= 2 so it is never last.
          state_next               = S_RUN;
          {strobe_next, ph_next}   = tbl_rdata;
          slot_next                = s_reg;
          busy_next                = 1'b1;
          s_next                   = SW'(1);
        end
      end
      S_RUN: begin
        {strobe_next, ph_next} = tbl_rdata;
        slot_next              = s_reg;
        busy_next              = 1'b1;
        if (s_reg == s_last) begin
          // Wrap: cycle boundary is the only point where length may change
          // and where a dropped run (or a one-shot step) returns to idle.
          done_next = 1'b1;
          s_next    = '0;
          len_next  = pend_reg;
          if (!run) begin
            state_next = S_IDLE;
          end
        end else begin
          s_next = s_reg + SW'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
        s_next     = '0;
      end
    endcase
  end

  // State and registered outputs; reset overrides every other input.
  always_ff @(posedge in) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      s_reg      <= '0;
      len_reg    <= LEN_MAX;
      pend_reg   <= LEN_MAX;
      ph_reg     <= '0;
      strobe_reg <= 1'b0;
      slot_reg   <= '0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      s_reg      <= s_next;
      len_reg    <= len_next;
      pend_reg   <= pend_next;
      ph_reg     <= ph_next;
      strobe_reg <= strobe_next;
      slot_reg   <= slot_next;
      done_reg   <= done_next;
      busy_reg   <= busy_next;
    end
  end

  assign ph         = ph_reg;
  assign strobe     = strobe_reg;
  assign slot       = slot_reg;
  assign cycle_done = done_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_phase_seq.sv
// Directed bench for phase_seq with NPH=2, SLOTS=4. Outputs are observed
// 1 time unit after each rising edge as {busy, cycle_done, slot, strobe, ph}.
module tb_phase_seq;

  localparam int NPH   = 2;
  localparam int SLOTS = 4;
  localparam int SW    = 2;

  // Expected observation words {busy, cycle_done, slot[1:0], strobe, ph[1:0]}.
  localparam logic [6:0] PI  = 7'b0_0_00_0_00; // idle
  localparam logic [6:0] P0  = 7'b1_0_00_0_01; // slot 0 default 0_01
  localparam logic [6:0] P1  = 7'b1_0_01_0_10; // slot 1 default 0_10
  localparam logic [6:0] P2  = 7'b1_0_10_1_01; // slot 2 default 1_01
  localparam logic [6:0] P3  = 7'b1_1_11_0_00; // slot 3 default 0_00, last
  localparam logic [6:0] P1N = 7'b1_0_01_1_11; // slot 1 rewritten to 1_11
  localparam logic [6:0] P1D = 7'b1_1_01_0_10; // slot 1 as last slot (L=2)

  logic           in = 1'b0;
  logic           rst, run, step, len_we, cfg_we;
  logic [SW:0]    len_d;
  logic [SW-1:0]  cfg_addr;
  logic [NPH:0]   cfg_data;
  logic [NPH-1:0] ph;
  logic           strobe;
  logic [SW-1:0]  slot;
  logic           cycle_done, busy;

  int npass  = 0;
  int ntotal = 0;

  always #5 in = ~in;

  phase_seq #(
    .NPH   (NPH),
    .SLOTS (SLOTS)
  ) dut (
    .in         (in),
    .rst        (rst),
    .run        (run),
    .step       (step),
    .len_we     (len_we),
    .len_d      (len_d),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .ph         (ph),
    .strobe     (strobe),
    .slot       (slot),
    .cycle_done (cycle_done),
    .busy       (busy)
  );

  wire [6:0] obs = {busy, cycle_done, slot, strobe, ph};

  task automatic tick();
    @(posedge in);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0; len_we = 1'b0; len_d = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    tick();
    rst = 1'b0;
  endtask

  // Reset with every other control asserted: reset must win, table and
  // length must stay at defaults.
  task automatic test_reset();
    logic [6:0] exp [0:5];
    exp = '{PI, PI, P0, P1, P2, P3};
    rst = 1'b1; run = 1'b1; step = 1'b1; len_we = 1'b1; len_d = 3'd2;
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 3'b111;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) begin
        rst = 1'b0; run = 1'b0; step = 1'b0; len_we = 1'b0; cfg_we = 1'b0;
      end
      if (i == 2) run = 1'b1;
      tick();
      ntotal++;
      if (obs !== exp[i]) $display("FAIL reset[%0d]: got %b want %b", i, obs, exp[i]);
      else begin npass++; $display("reset[%0d]: %b", i, obs); end
    end
  endtask

  // Continuous run repeats the default pattern with cycle_done on slot 3.
  task automatic test_run();
    logic [6:0] exp [0:3];
    exp = '{P0, P1, P2, P3};
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      ntotal++;
      if (obs !== exp[i % 4]) $display("FAIL run[%0d]: got %b want %b", i, obs, exp[i % 4]);
      else begin npass++; $display("run[%0d]: %b", i, obs); end
    end
  endtask

  // Dropping run during slot 1 still completes slots 2 and 3, then idles.
  task automatic test_halt();
    logic [6:0] exp [0:5];
    exp = '{P0, P1, P2, P3, PI, PI};
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) run = 1'b0;
      tick();
      ntotal++;
      if (obs !== exp[i]) $display("FAIL halt[%0d]: got %b want %b", i, obs, exp[i]);
      else begin npass++; $display("halt[%0d]: %b", i, obs); end
    end
  endtask

  // A step pulse runs exactly one cycle; a second step mid-cycle is ignored.
  task automatic test_step();
    logic [6:0] exp [0:6];
    int ndone;
    exp = '{P0, P1, P2, P3, PI, PI, PI};
    ndone = 0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step = (i == 0 || i == 2);
      tick();
      if (cycle_done === 1'b1) ndone++;
      ntotal++;
      if (obs !== exp[i]) $display("FAIL step[%0d]: got %b want %b", i, obs, exp[i]);
      else begin npass++; $display("step[%0d]: %b", i, obs); end
    end
    step = 1'b0;
    ntotal++;
    if (ndone !== 1) $display("FAIL step_done_count: got %0d want 1", ndone);
    else begin npass++; $display("step_done_count: %0d", ndone); end
  endtask

  // Length changes wait for the wrap; out-of-range requests are clamped.
  task automatic test_len();
    logic [6:0] exp_a [0:7];
    logic [6:0] exp_b [0:10];
    exp_a = '{P0, P1, P2, P3, P0, P1D, P0, P1D};
    do_reset();
    run = 1'b1; len_d = 3'd2;
    for (int i = 0; i < 8; i++) begin
      len_we = (i == 1);
      tick();
      ntotal++;
      if (obs !== exp_a[i]) $display("FAIL len2[%0d]: got %b want %b", i, obs, exp_a[i]);
      else begin npass++; $display("len2[%0d]: %b", i, obs); end
    end
    len_we = 1'b0;
    // len_d=0 requested while idle behaves as length 2; len_d=7 later as 4.
    exp_b = '{PI, P0, P1D, P0, P1D, P0, P1D, P0, P1, P2, P3};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      run    = (i != 0);
      len_we = (i == 0 || i == 5);
      len_d  = (i == 0) ? 3'd0 : 3'd7;
      tick();
      ntotal++;
      if (obs !== exp_b[i]) $display("FAIL clamp[%0d]: got %b want %b", i, obs, exp_b[i]);
      else begin npass++; $display("clamp[%0d]: %b", i, obs); end
    end
    len_we = 1'b0;
  endtask

  // Writing slot 1 while it is read: old value now, new value next pass.
  task automatic test_cfg();
    logic [6:0] exp [0:7];
    exp = '{P0, P1, P2, P3, P0, P1N, P2, P3};
    do_reset();
    run = 1'b1; cfg_addr = 2'd1; cfg_data = 3'b111;
    for (int i = 0; i < 8; i++) begin
      cfg_we = (i == 1);
      tick();
      ntotal++;
      if (obs !== exp[i]) $display("FAIL cfg[%0d]: got %b want %b", i, obs, exp[i]);
      else begin npass++; $display("cfg[%0d]: %b", i, obs); end
    end
    cfg_we = 1'b0;
  endtask

  // Reset in slot 2 while running clears outputs and restores the table.
  task automatic test_reset_mid();
    logic [6:0] exp [0:8];
    exp = '{PI, P0, P1N, P2, PI, P0, P1, P2, P3};
    do_reset();
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 3'b111;
    for (int i = 0; i < 9; i++) begin
      cfg_we = (i == 0);
      run    = (i != 0);
      rst    = (i == 4);
      tick();
      ntotal++;
      if (obs !== exp[i]) $display("FAIL rst_mid[%0d]: got %b want %b", i, obs, exp[i]);
      else begin npass++; $display("rst_mid[%0d]: %b", i, obs); end
    end
    rst = 1'b0; run = 1'b0;
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; step = 1'b0; len_we = 1'b0; len_d = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    test_reset();
    test_run();
    test_halt();
    test_step();
    test_len();
    test_cfg();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
